// File: rtl/pgm_bus_pkg.sv
// Shared types and constants for the PGM 68000 bus responders.
package pgm_bus_pkg;

  localparam int BUS_ADDR_W = 23;
  localparam logic [15:0] BUS_IDLE_DATA = 16'hFFFF;

  // Responder bus-cycle states. DRAIN is reserved and falls straight back to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_DTACK = 3'd2,
    ST_BERR  = 3'd3,
    ST_DRAIN = 3'd4
  } resp_state_t;

  // Read data as the CPU sees it: lanes that were not strobed float high.
  function automatic logic [15:0] lane_merge(input logic [1:0] be, input logic [15:0] data);
    logic [15:0] merged;
    merged[15:8] = be[1] ? data[15:8] : 8'hFF;
    merged[7:0]  = be[0] ? data[7:0]  : 8'hFF;
    return merged;
  endfunction

endpackage

// File: rtl/pgm_m68k_responder.sv
// Registered 68000 slave responder: turns one AS/UDS/LDS bus cycle into a single
// req/ack transaction on a generic memory port, answering with DTACK or BERR.
module pgm_m68k_responder
  import pgm_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  fixed_20m_clk,
  input  logic                  reset_n,
  input  logic [BUS_ADDR_W-1:0] cpu_adr,
  input  logic [15:0]           cpu_dout,
  input  logic                  cpu_as_n,
  input  logic                  cpu_uds_n,
  input  logic                  cpu_lds_n,
  input  logic                  cpu_rw_n,
  input  logic                  sel,
  output logic [15:0]           cpu_din,
  output logic                  cpu_dtack_n,
  output logic                  cpu_berr_n,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [BUS_ADDR_W-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic [1:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [15:0]           mem_rdata
);

  // The counter holds the number of REQ cycles already spent waiting; the bus
  // error fires on the edge that finds it equal to the limit, which puts the
  // BERR edge TIMEOUT_CYCLES+1 cycles after mem_req rose.
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  resp_state_t state_reg, state_next;

  logic [15:0]           din_reg, din_next;
  logic                  dtack_n_reg, dtack_n_next;
  logic                  berr_n_reg, berr_n_next;
  logic                  req_reg, req_next;
  logic                  we_reg, we_next;
  logic [BUS_ADDR_W-1:0] addr_reg, addr_next;
  logic [15:0]           wdata_reg, wdata_next;
  logic [1:0]            be_reg, be_next;
  logic [7:0]            count_reg, count_next;
  logic                  served_reg, served_next;

  logic start_cycle;

  // A new transaction may only start once per AS assertion, and only when a
  // data strobe is visible (writes assert UDS/LDS later than AS).
  assign start_cycle = !cpu_as_n && sel && !served_reg && (!cpu_uds_n || !cpu_lds_n);

  // State register.
  always_ff @(posedge fixed_20m_clk) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_cycle) state_next = ST_REQ;
      end
      ST_REQ: begin
        // served_reg drops if AS went away at any point during the request, so
        // an ack landing after a re-asserted AS never acknowledges the new cycle.
        if (mem_ack) begin
          state_next = (!cpu_as_n && served_reg) ? ST_DTACK : ST_IDLE;
        end else if (count_reg == TIMEOUT_LIMIT) begin
          state_next = ST_BERR;
        end
      end
      ST_DTACK: begin
        if (cpu_as_n) state_next = ST_IDLE;
      end
      ST_BERR: begin
        if (cpu_as_n) state_next = ST_IDLE;
      end
      ST_DRAIN: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output/datapath next values, all derived so every port comes from a flop.
  always_comb begin
    din_next     = din_reg;
    we_next      = we_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    be_next      = be_reg;
    count_next   = count_reg;
    served_next  = served_reg;

    if (cpu_as_n) served_next = 1'b0;

    if (state_reg == ST_IDLE && state_next == ST_REQ) begin
      addr_next   = cpu_adr;
      we_next     = ~cpu_rw_n;
      be_next     = {~cpu_uds_n, ~cpu_lds_n};
      wdata_next  = cpu_dout;
      count_next  = 8'd0;
      served_next = 1'b1;
    end

    if (state_reg == ST_REQ && !mem_ack) count_next = count_reg + 8'd1;

    if (state_reg == ST_REQ && state_next == ST_DTACK && !we_reg) begin
      din_next = lane_merge(be_reg, mem_rdata);
    end else if (state_next != ST_DTACK) begin
      din_next = BUS_IDLE_DATA;
    end

    req_next     = (state_next == ST_REQ);
    dtack_n_next = (state_next != ST_DTACK);
    berr_n_next  = (state_next != ST_BERR);
  end

  // Output and datapath registers.
  always_ff @(posedge fixed_20m_clk) begin
    if (!reset_n) begin
      din_reg     <= BUS_IDLE_DATA;
      dtack_n_reg <= 1'b1;
      berr_n_reg  <= 1'b1;
      req_reg     <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= 16'h0000;
      be_reg      <= 2'b00;
      count_reg   <= 8'd0;
      served_reg  <= 1'b0;
    end else begin
      din_reg     <= din_next;
      dtack_n_reg <= dtack_n_next;
      berr_n_reg  <= berr_n_next;
      req_reg     <= req_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      be_reg      <= be_next;
      count_reg   <= count_next;
      served_reg  <= served_next;
    end
  end

  assign cpu_din     = din_reg;
  assign cpu_dtack_n = dtack_n_reg;
  assign cpu_berr_n  = berr_n_reg;
  assign mem_req     = req_reg;
  assign mem_we      = we_reg;
  assign mem_addr    = addr_reg;
  assign mem_wdata   = wdata_reg;
  assign mem_be      = be_reg;

endmodule

// File: tb/tb_pgm_m68k_responder.sv
// Directed bench for pgm_m68k_responder: a default-timeout instance for the
// normal bus cycles and a TIMEOUT_CYCLES=4 instance for the bus-error path.
module tb_pgm_m68k_responder;
  import pgm_bus_pkg::*;

  logic clk;
  logic reset_n;
  logic [BUS_ADDR_W-1:0] cpu_adr;
  logic [15:0] cpu_dout;
  logic cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw_n;
  logic sel, sel_to;
  logic mem_ack, mem_ack_to;
  logic [15:0] mem_rdata;

  logic [15:0] cpu_din, cpu_din_to;
  logic cpu_dtack_n, cpu_dtack_n_to;
  logic cpu_berr_n, cpu_berr_n_to;
  logic mem_req, mem_req_to;
  logic mem_we, mem_we_to;
  logic [BUS_ADDR_W-1:0] mem_addr, mem_addr_to;
  logic [15:0] mem_wdata, mem_wdata_to;
  logic [1:0] mem_be, mem_be_to;

  int vectors = 0;
  int miscompares = 0;

  pgm_m68k_responder u_dut (
    .fixed_20m_clk(clk), .reset_n(reset_n),
    .cpu_adr(cpu_adr), .cpu_dout(cpu_dout),
    .cpu_as_n(cpu_as_n), .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .cpu_rw_n(cpu_rw_n),
    .sel(sel),
    .cpu_din(cpu_din), .cpu_dtack_n(cpu_dtack_n), .cpu_berr_n(cpu_berr_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  pgm_m68k_responder #(.TIMEOUT_CYCLES(4)) u_to (
    .fixed_20m_clk(clk), .reset_n(reset_n),
    .cpu_adr(cpu_adr), .cpu_dout(cpu_dout),
    .cpu_as_n(cpu_as_n), .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .cpu_rw_n(cpu_rw_n),
    .sel(sel_to),
    .cpu_din(cpu_din_to), .cpu_dtack_n(cpu_dtack_n_to), .cpu_berr_n(cpu_berr_n_to),
    .mem_req(mem_req_to), .mem_we(mem_we_to), .mem_addr(mem_addr_to),
    .mem_wdata(mem_wdata_to), .mem_be(mem_be_to),
    .mem_ack(mem_ack_to), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    cpu_as_n  = 1'b1;
    cpu_uds_n = 1'b1;
    cpu_lds_n = 1'b1;
    cpu_rw_n  = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_adr = '0;
    cpu_dout = 16'h0000;
    bus_idle();
    sel = 1'b0;
    sel_to = 1'b0;
    mem_ack = 1'b0;
    mem_ack_to = 1'b0;
    mem_rdata = 16'h0000;
    repeat (3) tick();

    // Reset state
    chk("rst_dtack", cpu_dtack_n, 1'b1);
    chk("rst_berr", cpu_berr_n, 1'b1);
    chk("rst_din", cpu_din, 16'hFFFF);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 23'h0);
    chk("rst_wdata", mem_wdata, 16'h0000);
    chk("rst_be", mem_be, 2'b00);
    reset_n = 1'b1;
    tick();

    // Read with ack in the first REQ cycle
    sel = 1'b1;
    cpu_adr = 23'h000010;
    cpu_as_n = 1'b0; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_rw_n = 1'b1;
    tick();
    chk("rd_req", mem_req, 1'b1);
    chk("rd_addr", mem_addr, 23'h000010);
    chk("rd_we", mem_we, 1'b0);
    chk("rd_be", mem_be, 2'b11);
    chk("rd_dtack_early", cpu_dtack_n, 1'b1);
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    chk("rd_req_drop", mem_req, 1'b0);
    chk("rd_dtack", cpu_dtack_n, 1'b0);
    chk("rd_din", cpu_din, 16'h1234);
    tick(); tick();
    chk("rd_dtack_hold", cpu_dtack_n, 1'b0);
    chk("rd_din_hold", cpu_din, 16'h1234);
    chk("rd_no_rereq", mem_req, 1'b0);
    bus_idle();
    tick();
    chk("rd_dtack_rel", cpu_dtack_n, 1'b1);
    chk("rd_din_idle", cpu_din, 16'hFFFF);

    // Upper-byte write, ack after 5 REQ cycles
    cpu_adr = 23'h002000; cpu_dout = 16'hAB00;
    cpu_as_n = 1'b0; cpu_uds_n = 1'b0; cpu_lds_n = 1'b1; cpu_rw_n = 1'b0;
    tick();
    chk("wr_req", mem_req, 1'b1);
    chk("wr_we", mem_we, 1'b1);
    chk("wr_be", mem_be, 2'b10);
    chk("wr_wdata", mem_wdata, 16'hAB00);
    chk("wr_addr", mem_addr, 23'h002000);
    repeat (4) tick();
    chk("wr_req_wait", mem_req, 1'b1);
    chk("wr_dtack_wait", cpu_dtack_n, 1'b1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("wr_dtack", cpu_dtack_n, 1'b0);
    chk("wr_req_drop", mem_req, 1'b0);
    chk("wr_din", cpu_din, 16'hFFFF);
    bus_idle();
    tick();
    chk("wr_dtack_rel", cpu_dtack_n, 1'b1);

    // Write whose data strobes lag AS by two cycles
    cpu_adr = 23'h000100; cpu_dout = 16'h5A5A;
    cpu_as_n = 1'b0; cpu_rw_n = 1'b0;
    tick();
    chk("lag_no_req1", mem_req, 1'b0);
    tick();
    chk("lag_no_req2", mem_req, 1'b0);
    cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
    tick();
    chk("lag_req", mem_req, 1'b1);
    chk("lag_be", mem_be, 2'b11);
    chk("lag_wdata", mem_wdata, 16'h5A5A);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("lag_dtack", cpu_dtack_n, 1'b0);
    tick();
    chk("lag_single_req1", mem_req, 1'b0);
    tick();
    chk("lag_single_req2", mem_req, 1'b0);
    bus_idle();
    tick();
    chk("lag_dtack_rel", cpu_dtack_n, 1'b1);

    // AS negated during REQ; ack arrives 3 cycles later
    cpu_adr = 23'h000030;
    cpu_as_n = 1'b0; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_rw_n = 1'b1;
    tick();
    chk("ab_req", mem_req, 1'b1);
    bus_idle();
    tick();
    chk("ab_req_kept", mem_req, 1'b1);
    tick(); tick();
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    chk("ab_req_drop", mem_req, 1'b0);
    chk("ab_no_dtack", cpu_dtack_n, 1'b1);
    chk("ab_din", cpu_din, 16'hFFFF);
    tick();
    chk("ab_no_dtack2", cpu_dtack_n, 1'b1);
    // Following cycle, lower byte only: upper lane must read FF
    cpu_adr = 23'h000040;
    cpu_as_n = 1'b0; cpu_uds_n = 1'b1; cpu_lds_n = 1'b0; cpu_rw_n = 1'b1;
    tick();
    chk("ab_next_req", mem_req, 1'b1);
    chk("ab_next_addr", mem_addr, 23'h000040);
    chk("ab_next_be", mem_be, 2'b01);
    mem_ack = 1'b1; mem_rdata = 16'hCAFE;
    tick();
    mem_ack = 1'b0;
    chk("ab_next_dtack", cpu_dtack_n, 1'b0);
    chk("ab_next_din", cpu_din, 16'hFFFE);
    bus_idle();
    tick();
    chk("ab_next_rel", cpu_dtack_n, 1'b1);

    // Timeout on the TIMEOUT_CYCLES=4 instance
    sel = 1'b0; sel_to = 1'b1;
    cpu_adr = 23'h000050;
    cpu_as_n = 1'b0; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_rw_n = 1'b1;
    tick();
    chk("to_req", mem_req_to, 1'b1);
    chk("to_other_idle", mem_req, 1'b0);
    repeat (4) tick();
    chk("to_req_still", mem_req_to, 1'b1);
    chk("to_berr_not_yet", cpu_berr_n_to, 1'b1);
    tick();
    chk("to_req_drop", mem_req_to, 1'b0);
    chk("to_berr", cpu_berr_n_to, 1'b0);
    mem_ack_to = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_ack_to = 1'b0;
    chk("to_late_ack_dtack", cpu_dtack_n_to, 1'b1);
    chk("to_berr_hold", cpu_berr_n_to, 1'b0);
    chk("to_other_dtack", cpu_dtack_n, 1'b1);
    bus_idle();
    tick();
    chk("to_berr_rel", cpu_berr_n_to, 1'b1);
    chk("to_dtack_rel", cpu_dtack_n_to, 1'b1);

    // Reset while a request is outstanding
    sel_to = 1'b0; sel = 1'b1;
    cpu_adr = 23'h000060;
    cpu_as_n = 1'b0; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_rw_n = 1'b1;
    tick();
    chk("mr_req", mem_req, 1'b1);
    reset_n = 1'b0;
    tick();
    chk("mr_req_drop", mem_req, 1'b0);
    chk("mr_dtack", cpu_dtack_n, 1'b1);
    chk("mr_berr", cpu_berr_n, 1'b1);
    chk("mr_din", cpu_din, 16'hFFFF);
    bus_idle();
    tick();
    reset_n = 1'b1;
    tick();
    chk("mr_idle_after", mem_req, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
